// File: rtl/add2_bist.sv
// add2_bist: built-in self-test controller for the add2 circuit under test.
// A 5-bit maximal-length LFSR supplies test patterns and a 3-bit MISR
// compacts the CUT responses; the final signature is compared against
// GOLDEN_SIG.
//
// Ports:
//   clk       in   1  clock, all state updates on the rising edge
//   rst       in   1  synchronous active-high reset
//   start     in   1  one-cycle request to begin a self-test run
//   pat       out  5  pattern to the CUT (pat[0]..pat[4] -> N1..N5)
//   pat_valid out  1  pat carries a live pattern
//   resp      in   3  CUT response (N50..N52), combinational from pat
//   busy      out  1  high from INIT through the last RUN cycle
//   done      out  1  high while in DONE
//   pass      out  1  signature matches GOLDEN_SIG, only while done
//   sig       out  3  current MISR contents
module add2_bist #(
    parameter int unsigned NUM_PATTERNS = 31,
    parameter logic [2:0]  GOLDEN_SIG   = 3'b000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [4:0] pat,
    output logic       pat_valid,
    input  logic [2:0] resp,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] sig
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Counter value of the final pattern; RUN ends on the edge that absorbs it.
    localparam logic [4:0] LAST_CNT = 5'(NUM_PATTERNS - 1);

    localparam logic [4:0] LFSR_SEED = 5'b00001;
    localparam logic [2:0] MISR_SEED = 3'b000;

    state_t     state_r;
    state_t     next_state_s;
    logic [4:0] lfsr_r;
    logic [2:0] misr_r;
    logic [4:0] cnt_r;

    // Fibonacci shift-left LFSR, x^5 + x^3 + 1; cycles through all 31 nonzero states.
    function automatic logic [4:0] lfsr_step(input logic [4:0] s);
        lfsr_step = {s[3:0], s[4] ^ s[2]};
    endfunction

    // MISR step, x^3 + x + 1, folding one response word into the signature.
    function automatic logic [2:0] misr_step(input logic [2:0] s, input logic [2:0] r);
        misr_step = {s[1] ^ r[2], s[0] ^ s[2] ^ r[1], s[2] ^ r[0]};
    endfunction

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; start is only honoured in IDLE and DONE.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_state_s = ST_INIT;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_INIT: begin
                next_state_s = ST_RUN;
            end
            ST_RUN: begin
                if (cnt_r == LAST_CNT) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (start) begin
                    next_state_s = ST_INIT;
                end else begin
                    next_state_s = ST_DONE;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Datapath registers: seeded in INIT, stepped every RUN cycle, held otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_r <= LFSR_SEED;
            misr_r <= MISR_SEED;
            cnt_r  <= 5'd0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    lfsr_r <= LFSR_SEED;
                    misr_r <= MISR_SEED;
                    cnt_r  <= 5'd0;
                end
                ST_RUN: begin
                    lfsr_r <= lfsr_step(lfsr_r);
                    misr_r <= misr_step(misr_r, resp);
                    cnt_r  <= cnt_r + 5'd1;
                end
                default: begin
                    lfsr_r <= lfsr_r;
                    misr_r <= misr_r;
                    cnt_r  <= cnt_r;
                end
            endcase
        end
    end

    // Output decode from the state and datapath registers (glitch-free sources).
    always_comb begin
        pat       = 5'b00000;
        pat_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        pass      = 1'b0;
        case (state_r)
            ST_INIT: begin
                busy = 1'b1;
            end
            ST_RUN: begin
                pat       = lfsr_r;
                pat_valid = 1'b1;
                busy      = 1'b1;
            end
            ST_DONE: begin
                done = 1'b1;
                pass = (misr_r == GOLDEN_SIG);
            end
            default: begin
                pat = 5'b00000;
            end
        endcase
    end

    assign sig = misr_r;

endmodule
